// File: rtl/imm_encoder_if.sv
// Request/response bundle for the RV32 immediate encoder.
interface imm_encoder_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_fmt;
    logic [6:0]  req_opcode;
    logic [4:0]  req_rd;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic [2:0]  req_funct3;
    logic [31:0] req_value;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_last;
    logic        out_err;

    // Producer of requests / consumer of instruction words
    modport master (
        output req_valid, req_fmt, req_opcode, req_rd, req_rs1, req_rs2,
               req_funct3, req_value, out_ready,
        input  req_ready, out_valid, out_instr, out_last, out_err
    );

    // The encoder itself
    modport slave (
        input  req_valid, req_fmt, req_opcode, req_rd, req_rs1, req_rs2,
               req_funct3, req_value, out_ready,
        output req_ready, out_valid, out_instr, out_last, out_err
    );
endinterface

// File: rtl/imm_encoder.sv
// Encodes an immediate into an RV32 instruction word (I/S/B/U/J) or expands
// a load-immediate macro into ADDI, LUI, or LUI+ADDI.
module imm_encoder (
    input  logic         clk,
    input  logic         rstn,
    imm_encoder_if.slave bus
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned IMM_W = 12;
    localparam int unsigned REG_W = 5;

    localparam logic [2:0] FMT_I  = 3'd0;
    localparam logic [2:0] FMT_S  = 3'd1;
    localparam logic [2:0] FMT_B  = 3'd2;
    localparam logic [2:0] FMT_U  = 3'd3;
    localparam logic [2:0] FMT_J  = 3'd4;
    localparam logic [2:0] FMT_LI = 3'd5;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    typedef enum logic [1:0] {IDLE, EMIT1, EMIT2} state_t;

    state_t             state_q, state_d;
    logic [XLEN-1:0]    instr_q, instr_d;
    logic               last_q, last_d;
    logic               err_q, err_d;
    logic [REG_W-1:0]   rd_q, rd_d;
    logic [IMM_W-1:0]   lo_q, lo_d;

    logic [XLEN-1:0]    li_lo;
    logic [XLEN-1:0]    li_hi;
    logic               fits_12;
    logic               fits_13;
    logic               fits_21;
    logic [XLEN-1:0]    enc_word;
    logic               enc_last;
    logic               enc_err;

    // Signed range tests: upper bits must replicate the field's sign bit
    assign fits_12 = (bus.req_value[31:11] == {21{bus.req_value[11]}});
    assign fits_13 = (bus.req_value[31:12] == {20{bus.req_value[12]}});
    assign fits_21 = (bus.req_value[31:20] == {12{bus.req_value[20]}});

    // First word of the request, computed from the live request fields
    always_comb begin
        enc_word = '0;
        enc_last = 1'b1;
        enc_err  = 1'b0;
        li_lo    = {{(XLEN-IMM_W){bus.req_value[11]}}, bus.req_value[11:0]};
        li_hi    = bus.req_value - li_lo;
        case (bus.req_fmt)
            FMT_I: begin
                if (fits_12) enc_word = {bus.req_value[11:0], bus.req_rs1, bus.req_funct3,
                                         bus.req_rd, bus.req_opcode};
                else         enc_err  = 1'b1;
            end
            FMT_S: begin
                if (fits_12) enc_word = {bus.req_value[11:5], bus.req_rs2, bus.req_rs1,
                                         bus.req_funct3, bus.req_value[4:0], bus.req_opcode};
                else         enc_err  = 1'b1;
            end
            FMT_B: begin
                if (fits_13 && !bus.req_value[0])
                    enc_word = {bus.req_value[12], bus.req_value[10:5], bus.req_rs2,
                                bus.req_rs1, bus.req_funct3, bus.req_value[4:1],
                                bus.req_value[11], bus.req_opcode};
                else
                    enc_err = 1'b1;
            end
            FMT_U: begin
                if (bus.req_value[11:0] == '0)
                    enc_word = {bus.req_value[31:12], bus.req_rd, bus.req_opcode};
                else
                    enc_err = 1'b1;
            end
            FMT_J: begin
                if (fits_21 && !bus.req_value[0])
                    enc_word = {bus.req_value[20], bus.req_value[10:1], bus.req_value[11],
                                bus.req_value[19:12], bus.req_rd, bus.req_opcode};
                else
                    enc_err = 1'b1;
            end
            FMT_LI: begin
                if (li_hi == '0) begin
                    enc_word = {bus.req_value[11:0], 5'd0, 3'b000, bus.req_rd, OPC_OP_IMM};
                end else begin
                    enc_word = {li_hi[31:12], bus.req_rd, OPC_LUI};
                    enc_last = (bus.req_value[11:0] == '0);
                end
            end
            default: enc_err = 1'b1;
        endcase
    end

    // Next-state and next-output logic; the ADDI tail is built from registered fields
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        last_d  = last_q;
        err_d   = err_q;
        rd_d    = rd_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    state_d = EMIT1;
                    instr_d = enc_word;
                    last_d  = enc_last;
                    err_d   = enc_err;
                    rd_d    = bus.req_rd;
                    lo_d    = bus.req_value[11:0];
                end
            end
            EMIT1: begin
                if (bus.out_ready) begin
                    if (last_q) begin
                        state_d = IDLE;
                        instr_d = '0;
                        last_d  = 1'b0;
                        err_d   = 1'b0;
                    end else begin
                        state_d = EMIT2;
                        instr_d = {lo_q, rd_q, 3'b000, rd_q, OPC_OP_IMM};
                        last_d  = 1'b1;
                        err_d   = 1'b0;
                    end
                end
            end
            EMIT2: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                    instr_d = '0;
                    last_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, output and request registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            instr_q <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            last_q  <= last_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.out_valid = (state_q != IDLE);
    assign bus.out_instr = instr_q;
    assign bus.out_last  = last_q;
    assign bus.out_err   = err_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed vectors, stall/reset
// sequences, and randomized requests against a behavioural model.
module tb_imm_encoder;
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    imm_encoder_if bus_if ();

    imm_encoder dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_if)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic        last;
        logic        err;
    } word_t;

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  opc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [31:0] value;
        int          nw;
        logic [31:0] w0;
        logic        l0;
        logic        e0;
        logic [31:0] w1;
    } vec_t;

    word_t exp_q[$];
    vec_t  vecs[18];
    int    bnd[14] = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4098,
                       1048574, 1048576, -1048576, -1048578, 0, 4096};
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w, input logic l, input logic e);
        word_t x;
        x.instr = w;
        x.last  = l;
        x.err   = e;
        exp_q.push_back(x);
    endtask

    // Reference model: range rules with signed arithmetic, LI split by hi/lo math
    task automatic model(input logic [2:0] fmt, input logic [6:0] opc, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [31:0] value);
        int          sv;
        int          lo;
        logic [31:0] lo_w;
        logic [31:0] hi;
        sv = int'(value);
        case (fmt)
            3'd0: if (sv >= -2048 && sv <= 2047)
                      push_word({value[11:0], rs1, f3, rd, opc}, 1'b1, 1'b0);
                  else push_word(32'h0, 1'b1, 1'b1);
            3'd1: if (sv >= -2048 && sv <= 2047)
                      push_word({value[11:5], rs2, rs1, f3, value[4:0], opc}, 1'b1, 1'b0);
                  else push_word(32'h0, 1'b1, 1'b1);
            3'd2: if (sv >= -4096 && sv <= 4094 && (sv % 2) == 0)
                      push_word({value[12], value[10:5], rs2, rs1, f3, value[4:1], value[11], opc},
                                1'b1, 1'b0);
                  else push_word(32'h0, 1'b1, 1'b1);
            3'd3: if ((value % 32'd4096) == 32'd0)
                      push_word({value[31:12], rd, opc}, 1'b1, 1'b0);
                  else push_word(32'h0, 1'b1, 1'b1);
            3'd4: if (sv >= -1048576 && sv <= 1048574 && (sv % 2) == 0)
                      push_word({value[20], value[10:1], value[11], value[19:12], rd, opc},
                                1'b1, 1'b0);
                  else push_word(32'h0, 1'b1, 1'b1);
            3'd5: begin
                lo = int'(value % 32'd4096);
                if (lo >= 2048) lo = lo - 4096;
                lo_w = 32'(lo);
                hi   = value - lo_w;
                if (hi == 32'd0) begin
                    push_word({lo_w[11:0], 5'd0, 3'd0, rd, 7'b0010011}, 1'b1, 1'b0);
                end else if (lo == 0) begin
                    push_word({hi[31:12], rd, 7'b0110111}, 1'b1, 1'b0);
                end else begin
                    push_word({hi[31:12], rd, 7'b0110111}, 1'b0, 1'b0);
                    push_word({lo_w[11:0], rd, 3'd0, rd, 7'b0010011}, 1'b1, 1'b0);
                end
            end
            default: push_word(32'h0, 1'b1, 1'b1);
        endcase
    endtask

    task automatic drive_req(input logic [2:0] fmt, input logic [6:0] opc, input logic [4:0] rd,
                             input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                             input logic [31:0] value);
        bus_if.req_fmt    = fmt;
        bus_if.req_opcode = opc;
        bus_if.req_rd     = rd;
        bus_if.req_rs1    = rs1;
        bus_if.req_rs2    = rs2;
        bus_if.req_funct3 = f3;
        bus_if.req_value  = value;
        bus_if.req_valid  = 1'b1;
    endtask

    // Present a request until accepted, then scramble the request fields
    task automatic accept_req(input string tag, output logic ok);
        logic rdy;
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            rdy = bus_if.req_ready;
            @(posedge clk); #1;
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        bus_if.req_valid  = 1'b0;
        bus_if.req_value  = $urandom;
        bus_if.req_rd     = 5'($urandom);
        bus_if.req_fmt    = 3'($urandom);
        check({tag, " accept"}, 32'(ok), 32'd1);
    endtask

    // Drain the words queued in exp_q for one request, stalling each word
    task automatic run_req(input string tag, input logic [2:0] fmt, input logic [6:0] opc,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [2:0] f3, input logic [31:0] value, input int stall);
        logic  ok;
        logic  done;
        word_t w;
        drive_req(fmt, opc, rd, rs1, rs2, f3, value);
        accept_req(tag, ok);
        if (!ok) begin
            exp_q.delete();
            return;
        end
        done = 1'b0;
        while (!done && exp_q.size() > 0) begin
            w = exp_q.pop_front();
            for (int s = 0; s < stall; s++) begin
                bus_if.out_ready = 1'b0;
                check({tag, " stall valid"}, 32'(bus_if.out_valid), 32'd1);
                check({tag, " stall instr"}, bus_if.out_instr, w.instr);
                check({tag, " stall last"},  32'(bus_if.out_last), 32'(w.last));
                check({tag, " stall err"},   32'(bus_if.out_err), 32'(w.err));
                check({tag, " stall req_ready"}, 32'(bus_if.req_ready), 32'd0);
                @(posedge clk); #1;
            end
            bus_if.out_ready = 1'b1;
            check({tag, " valid"}, 32'(bus_if.out_valid), 32'd1);
            check({tag, " instr"}, bus_if.out_instr, w.instr);
            check({tag, " last"},  32'(bus_if.out_last), 32'(w.last));
            check({tag, " err"},   32'(bus_if.out_err), 32'(w.err));
            @(posedge clk); #1;
            bus_if.out_ready = 1'b0;
            done = w.last;
        end
        exp_q.delete();
        check({tag, " idle valid"}, 32'(bus_if.out_valid), 32'd0);
        check({tag, " idle ready"}, 32'(bus_if.req_ready), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " out_valid"}, 32'(bus_if.out_valid), 32'd0);
        check({tag, " req_ready"}, 32'(bus_if.req_ready), 32'd1);
        check({tag, " out_instr"}, bus_if.out_instr, 32'd0);
        check({tag, " out_last"},  32'(bus_if.out_last), 32'd0);
        check({tag, " out_err"},   32'(bus_if.out_err), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic        ok;
        logic [2:0]  fmt;
        logic [31:0] value;

        vecs[0]  = '{3'd5, 7'h00, 5'd5,  5'd0, 5'd0, 3'd0, 32'h00000123, 1, 32'h12300293, 1'b1, 1'b0, 32'h0};
        vecs[1]  = '{3'd5, 7'h00, 5'd10, 5'd0, 5'd0, 3'd0, 32'h12345FFF, 2, 32'h12346537, 1'b0, 1'b0, 32'hFFF50513};
        vecs[2]  = '{3'd5, 7'h00, 5'd1,  5'd0, 5'd0, 3'd0, 32'h00001000, 1, 32'h000010B7, 1'b1, 1'b0, 32'h0};
        vecs[3]  = '{3'd2, 7'h63, 5'd0,  5'd1, 5'd2, 3'd1, 32'hFFFFFFFC, 1, 32'hFE209EE3, 1'b1, 1'b0, 32'h0};
        vecs[4]  = '{3'd2, 7'h63, 5'd0,  5'd1, 5'd2, 3'd1, 32'h00000003, 1, 32'h00000000, 1'b1, 1'b1, 32'h0};
        vecs[5]  = '{3'd0, 7'h13, 5'd1,  5'd2, 5'd0, 3'd0, 32'h00000800, 1, 32'h00000000, 1'b1, 1'b1, 32'h0};
        vecs[6]  = '{3'd0, 7'h13, 5'd1,  5'd2, 5'd0, 3'd0, 32'hFFFFF800, 1, 32'h80010093, 1'b1, 1'b0, 32'h0};
        vecs[7]  = '{3'd3, 7'h37, 5'd3,  5'd0, 5'd0, 3'd0, 32'hABCDE000, 1, 32'hABCDE1B7, 1'b1, 1'b0, 32'h0};
        vecs[8]  = '{3'd3, 7'h37, 5'd3,  5'd0, 5'd0, 3'd0, 32'h00001001, 1, 32'h00000000, 1'b1, 1'b1, 32'h0};
        vecs[9]  = '{3'd7, 7'h13, 5'd3,  5'd0, 5'd0, 3'd0, 32'h00000000, 1, 32'h00000000, 1'b1, 1'b1, 32'h0};
        vecs[10] = '{3'd4, 7'h6F, 5'd1,  5'd0, 5'd0, 3'd0, 32'h00000002, 1, 32'h002000EF, 1'b1, 1'b0, 32'h0};
        vecs[11] = '{3'd1, 7'h23, 5'd0,  5'd2, 5'd3, 3'd2, 32'h00000008, 1, 32'h00312423, 1'b1, 1'b0, 32'h0};
        vecs[12] = '{3'd5, 7'h00, 5'd0,  5'd0, 5'd0, 3'd0, 32'h00000000, 1, 32'h00000013, 1'b1, 1'b0, 32'h0};
        vecs[13] = '{3'd5, 7'h00, 5'd2,  5'd0, 5'd0, 3'd0, 32'h00000800, 2, 32'h00001137, 1'b0, 1'b0, 32'h80010113};
        vecs[14] = '{3'd2, 7'h63, 5'd0,  5'd1, 5'd2, 3'd1, 32'h00001000, 1, 32'h00000000, 1'b1, 1'b1, 32'h0};
        vecs[15] = '{3'd6, 7'h13, 5'd3,  5'd0, 5'd0, 3'd0, 32'h00000004, 1, 32'h00000000, 1'b1, 1'b1, 32'h0};
        vecs[16] = '{3'd4, 7'h6F, 5'd0,  5'd0, 5'd0, 3'd0, 32'hFFF00000, 1, 32'h8000006F, 1'b1, 1'b0, 32'h0};
        vecs[17] = '{3'd4, 7'h6F, 5'd0,  5'd0, 5'd0, 3'd0, 32'h00100000, 1, 32'h00000000, 1'b1, 1'b1, 32'h0};

        bus_if.req_valid  = 1'b0;
        bus_if.req_fmt    = 3'd0;
        bus_if.req_opcode = 7'd0;
        bus_if.req_rd     = 5'd0;
        bus_if.req_rs1    = 5'd0;
        bus_if.req_rs2    = 5'd0;
        bus_if.req_funct3 = 3'd0;
        bus_if.req_value  = 32'd0;
        bus_if.out_ready  = 1'b0;

        // Reset state
        #1;
        check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("post-reset");

        // Directed vectors
        foreach (vecs[i]) begin
            push_word(vecs[i].w0, vecs[i].l0, vecs[i].e0);
            if (vecs[i].nw == 2) push_word(vecs[i].w1, 1'b1, 1'b0);
            run_req($sformatf("vec%0d", i), vecs[i].fmt, vecs[i].opc, vecs[i].rd, vecs[i].rs1,
                    vecs[i].rs2, vecs[i].f3, vecs[i].value, 0);
        end

        // Back-pressure: each LUI/ADDI word held for three cycles
        push_word(32'h12346537, 1'b0, 1'b0);
        push_word(32'hFFF50513, 1'b1, 1'b0);
        run_req("stall3", 3'd5, 7'h00, 5'd10, 5'd0, 5'd0, 3'd0, 32'h12345FFF, 3);

        // Reset pulsed between the LUI handshake and the ADDI word
        drive_req(3'd5, 7'h00, 5'd10, 5'd0, 5'd0, 3'd0, 32'h12345FFF);
        accept_req("rstmid", ok);
        bus_if.out_ready = 1'b1;
        check("rstmid lui", bus_if.out_instr, 32'h12346537);
        @(posedge clk); #1;
        bus_if.out_ready = 1'b0;
        check("rstmid addi pending", bus_if.out_instr, 32'hFFF50513);
        #2;
        rstn = 1'b0;
        #1;
        check_reset_outputs("rstmid async");
        @(posedge clk); #1;
        rstn = 1'b1;
        bus_if.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            check("rstmid no stale valid", 32'(bus_if.out_valid), 32'd0);
            check("rstmid ready", 32'(bus_if.req_ready), 32'd1);
            @(posedge clk); #1;
        end
        bus_if.out_ready = 1'b0;
        model(3'd5, 7'h00, 5'd7, 5'd0, 5'd0, 3'd0, 32'h00000123);
        run_req("after-rst", 3'd5, 7'h00, 5'd7, 5'd0, 5'd0, 3'd0, 32'h00000123, 0);

        // Randomized requests against the model
        for (int n = 0; n < 300; n++) begin
            fmt = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) fmt = 3'($urandom_range(0, 5));
            case ($urandom_range(0, 4))
                0: value = $urandom;
                1: value = 32'($urandom_range(0, 8191)) - 32'd4096;
                2: value = $urandom & 32'hFFFFF000;
                3: value = 32'($urandom_range(0, 4194303)) - 32'd2097152;
                default: value = 32'(bnd[$urandom_range(0, 13)]);
            endcase
            begin
                logic [6:0] opc;
                logic [4:0] rd, rs1, rs2;
                logic [2:0] f3;
                opc = 7'($urandom);
                rd  = 5'($urandom);
                rs1 = 5'($urandom);
                rs2 = 5'($urandom);
                f3  = 3'($urandom);
                model(fmt, opc, rd, rs1, rs2, f3, value);
                run_req($sformatf("rnd%0d", n), fmt, opc, rd, rs1, rs2, f3, value,
                        int'($urandom_range(0, 2)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
